// File: rtl/day1_input_sequencer_if.sv
// rtl/day1_input_sequencer_if.sv - memory read port and step stream between the sequencer and its neighbours
interface day1_input_sequencer_if #(
    parameter int WIDTH  = 11,
    parameter int ADDR_W = 13
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_rdata;

    logic              step_valid;
    logic              step_ready;
    logic              step_dir;
    logic [WIDTH-2:0]  step_mag;
    logic              step_last;

    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_rdata,
        output step_valid,
        input  step_ready,
        output step_dir,
        output step_mag,
        output step_last
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_rdata,
        input  step_valid,
        output step_ready,
        input  step_dir,
        input  step_mag,
        input  step_last
    );
endinterface

// File: rtl/day1_input_sequencer.sv
// rtl/day1_input_sequencer.sv - plays the Day 1 rotation list into the dial accumulator through a 2-entry prefetch buffer
// Optional SEQ_ABORT_EN adds an abort input that discards buffered steps and ends the run.
module day1_input_sequencer #(
    parameter int DEPTH  = 4126,
    parameter int WIDTH  = 11,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    day1_input_sequencer_if.master bus,
    input  logic                   start,
    input  logic [ADDR_W:0]        num_records,
`ifdef SEQ_ABORT_EN
    input  logic                   abort,
`endif
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_W:0]        rec_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    state_t            r_state;
    state_t            w_next;

    logic [ADDR_W:0]   r_n;
    logic [ADDR_W:0]   r_rd_ptr;
    logic              r_inflight;
    logic              r_inflight_last;

    logic [WIDTH:0]    r_fifo_mem [2];
    logic              r_fifo_wp;
    logic              r_fifo_rp;
    logic [1:0]        r_fifo_cnt;

    logic              r_out_valid;
    logic              r_out_dir;
    logic [WIDTH-2:0]  r_out_mag;
    logic              r_out_last;

    logic [ADDR_W:0]   w_n_clamped;
    logic              w_start_ok;
    logic              w_abort;
    logic              w_hs;
    logic              w_last_hs;
    logic              w_rd_en;
    logic [2:0]        w_occ;
    logic              w_fifo_empty;
    logic              w_head_valid;
    logic [WIDTH:0]    w_head;
    logic              w_out_load;
    logic              w_push;
    logic              w_pop;

    assign w_n_clamped = (num_records > DEPTH_C) ? DEPTH_C : num_records;
    assign w_start_ok  = (r_state == S_IDLE) && start;

`ifdef SEQ_ABORT_EN
    assign w_abort = abort && ((r_state == S_RUN) || (r_state == S_FLUSH));
`else
    assign w_abort = 1'b0;
`endif

    assign w_hs      = r_out_valid && bus.step_ready;
    assign w_last_hs = w_hs && r_out_last;

    // Occupancy counts reads in flight so a full FIFO can never be overrun by returning data.
    assign w_occ        = {1'b0, r_fifo_cnt} + {2'b00, r_inflight};
    assign w_fifo_empty = (r_fifo_cnt == 2'd0);

    // Returning data bypasses an empty FIFO so the first step appears two cycles after its read.
    assign w_head_valid = !w_fifo_empty || r_inflight;
    assign w_head       = !w_fifo_empty ? r_fifo_mem[r_fifo_rp] : {r_inflight_last, bus.mem_rdata};
    assign w_out_load   = w_head_valid && (!r_out_valid || w_hs);
    assign w_push       = r_inflight && !(w_out_load && w_fifo_empty);
    assign w_pop        = w_out_load && !w_fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (num_records == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_abort) begin
                    w_next = S_DONE;
                end else if (r_rd_ptr == r_n) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_abort || w_last_hs) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        w_rd_en = 1'b0;
        case (r_state)
            S_RUN: begin
                busy    = 1'b1;
                w_rd_en = (r_rd_ptr < r_n) && (w_occ < 3'd2) && !w_abort;
            end
            S_FLUSH: begin
                busy = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign bus.mem_rd_en  = w_rd_en;
    assign bus.mem_addr   = w_rd_en ? r_rd_ptr[ADDR_W-1:0] : '0;
    assign bus.step_valid = r_out_valid;
    assign bus.step_dir   = r_out_dir;
    assign bus.step_mag   = r_out_mag;
    assign bus.step_last  = r_out_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n             <= '0;
            r_rd_ptr        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_fifo_mem[0]   <= '0;
            r_fifo_mem[1]   <= '0;
            r_fifo_wp       <= 1'b0;
            r_fifo_rp       <= 1'b0;
            r_fifo_cnt      <= 2'd0;
            r_out_valid     <= 1'b0;
            r_out_dir       <= 1'b0;
            r_out_mag       <= '0;
            r_out_last      <= 1'b0;
            rec_count       <= '0;
        end else begin
            if (w_start_ok) begin
                r_n       <= w_n_clamped;
                r_rd_ptr  <= '0;
                rec_count <= '0;
            end else if (w_hs) begin
                rec_count <= rec_count + ONE_C;
            end

            if (w_abort) begin
                r_inflight      <= 1'b0;
                r_inflight_last <= 1'b0;
                r_fifo_wp       <= 1'b0;
                r_fifo_rp       <= 1'b0;
                r_fifo_cnt      <= 2'd0;
                r_out_valid     <= 1'b0;
                r_out_dir       <= 1'b0;
                r_out_mag       <= '0;
                r_out_last      <= 1'b0;
            end else begin
                r_inflight      <= w_rd_en;
                r_inflight_last <= (r_rd_ptr == (r_n - ONE_C));
                if (w_rd_en) begin
                    r_rd_ptr <= r_rd_ptr + ONE_C;
                end

                if (w_push) begin
                    r_fifo_mem[r_fifo_wp] <= {r_inflight_last, bus.mem_rdata};
                    r_fifo_wp             <= ~r_fifo_wp;
                end
                if (w_pop) begin
                    r_fifo_rp <= ~r_fifo_rp;
                end
                r_fifo_cnt <= r_fifo_cnt + {1'b0, w_push} - {1'b0, w_pop};

                if (w_out_load) begin
                    r_out_valid <= 1'b1;
                    r_out_last  <= w_head[WIDTH];
                    r_out_dir   <= w_head[WIDTH-1];
                    r_out_mag   <= w_head[WIDTH-2:0];
                end else if (w_hs) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_day1_input_sequencer.sv
// tb/tb_day1_input_sequencer.sv - self-checking bench for day1_input_sequencer
module tb_day1_input_sequencer;

    localparam int DEPTH  = 4126;
    localparam int WIDTH  = 11;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef struct {
        int nrec;
        int mode;
        int exp_cnt;
        int exp_lat;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W:0]   num_records;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   rec_count;
`ifdef SEQ_ABORT_EN
    logic              abort;
`endif

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH:0]    sb [$];
    int                n_checks = 0;
    int                n_errors = 0;
    int                cur_n    = 0;
    int                rd_cnt   = 0;
    int                hs_cnt   = 0;
    bit                mon_en   = 1'b0;
    bit                prev_stall;
    logic [WIDTH:0]    prev_data;

    day1_input_sequencer_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    day1_input_sequencer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .start       (start),
        .num_records (num_records),
`ifdef SEQ_ABORT_EN
        .abort       (abort),
`endif
        .busy        (busy),
        .done        (done),
        .rec_count   (rec_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic pat(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return ((k % 4) == 0) || ((k % 4) == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic load_sb(input int n);
        for (int i = 0; i < n; i++) sb.push_back({(i == n - 1), mem[i]});
        cur_n  = n;
        rd_cnt = 0;
    endtask

    // Scoreboard monitor: samples on the falling edge, between input updates and the active edge.
    initial begin : monitor
        logic [WIDTH:0] act;
        logic [WIDTH:0] exp;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && mon_en) begin
                act = {bus.step_last, bus.step_dir, bus.step_mag};
                if (prev_stall) begin
                    check("hold_valid", bus.step_valid, 1);
                    check("hold_data", act, prev_data);
                end
                if (bus.mem_rd_en) begin
                    rd_cnt++;
                    check("addr_lt_n", (int'(bus.mem_addr) < cur_n), 1);
                end
                if (bus.step_valid && bus.step_ready) begin
                    hs_cnt++;
                    check("sb_has_entry", (sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        exp = sb.pop_front();
                        check("step", act, exp);
                    end
                end
                prev_stall = bus.step_valid && !bus.step_ready;
                prev_data  = act;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic run(input int nrec, input int mode, input int exp_cnt, input int exp_lat, input string tag);
        int n_eff;
        int k;
        int lat;
        n_eff = (nrec > DEPTH) ? DEPTH : nrec;
        load_sb(n_eff);
        mon_en         = 1'b1;
        start          = 1'b1;
        num_records    = (ADDR_W+1)'(nrec);
        bus.step_ready = pat(mode, 0);
        @(posedge clk); #1;
        start = 1'b0;
        k     = 0;
        lat   = -1;
        while (k < 6000) begin
            if (done) begin
                lat = k + 1;
                break;
            end
            bus.step_ready = pat(mode, k);
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_done_seen"}, (lat >= 0), 1);
        if (exp_lat >= 0) check({tag, "_done_lat"}, lat, exp_lat);
        check({tag, "_rec_count"}, rec_count, exp_cnt);
        check({tag, "_busy_at_done"}, busy, 0);
        check({tag, "_reads"}, rd_cnt, n_eff);
        check({tag, "_sb_empty"}, sb.size(), 0);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_valid_idle"}, bus.step_valid, 0);
        check({tag, "_count_hold"}, rec_count, exp_cnt);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_valid"}, bus.step_valid, 0);
        check({tag, "_dir"}, bus.step_dir, 0);
        check({tag, "_mag"}, bus.step_mag, 0);
        check({tag, "_last"}, bus.step_last, 0);
        check({tag, "_rd_en"}, bus.mem_rd_en, 0);
        check({tag, "_addr"}, bus.mem_addr, 0);
        check({tag, "_rec_count"}, rec_count, 0);
    endtask

    vec_t vecs [6];

    initial begin : stimulus
        int        k;
        logic      exp_dir  [4];
        int        exp_mag  [4];

        vecs[0] = '{4,    0, 4,    7};
        vecs[1] = '{5,    1, 5,    -1};
        vecs[2] = '{1,    0, 1,    4};
        vecs[3] = '{0,    0, 0,    1};
        vecs[4] = '{40,   2, 40,   -1};
        vecs[5] = '{5000, 0, 4126, 4129};

        for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom);

        rst_n          = 1'b0;
        start          = 1'b0;
        num_records    = '0;
        bus.step_ready = 1'b0;
`ifdef SEQ_ABORT_EN
        abort          = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full throughput with exact per-cycle timing.
        mem[0] = {1'b0, 10'd26};
        mem[1] = {1'b1, 10'd26};
        mem[2] = {1'b0, 10'd99};
        mem[3] = {1'b1, 10'd0};
        exp_dir = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_mag = '{26, 26, 99, 0};
        load_sb(4);
        mon_en         = 1'b1;
        start          = 1'b1;
        num_records    = (ADDR_W+1)'(4);
        bus.step_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            check($sformatf("tp_valid_t%0d", j), bus.step_valid, (j >= 3 && j <= 6));
            check($sformatf("tp_last_t%0d", j), bus.step_last && bus.step_valid, (j == 6));
            check($sformatf("tp_done_t%0d", j), done, (j == 7));
            check($sformatf("tp_busy_t%0d", j), busy, (j <= 6));
            if (j >= 3 && j <= 6) begin
                check($sformatf("tp_dir_t%0d", j), bus.step_dir, exp_dir[j-3]);
                check($sformatf("tp_mag_t%0d", j), bus.step_mag, exp_mag[j-3]);
            end
            if (j == 1) begin
                check("tp_rd_en_t1", bus.mem_rd_en, 1);
                check("tp_addr_t1", bus.mem_addr, 0);
            end
            @(posedge clk); #1;
        end
        check("tp_rec_count", rec_count, 4);
        check("tp_sb_empty", sb.size(), 0);

        for (int v = 0; v < 6; v++) begin
            run(vecs[v].nrec, vecs[v].mode, vecs[v].exp_cnt, vecs[v].exp_lat, $sformatf("vec%0d", v));
        end

        // Reset while stalled in FLUSH, then replay from address 0.
        mem[0] = {1'b0, 10'd26};
        mem[1] = {1'b1, 10'd26};
        mem[2] = {1'b0, 10'd5};
        load_sb(3);
        mon_en         = 1'b1;
        start          = 1'b1;
        num_records    = (ADDR_W+1)'(3);
        bus.step_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        check("mid_busy_before_reset", busy, 1);
        check("mid_valid_before_reset", bus.step_valid, 1);
        mon_en = 1'b0;
        sb.delete();
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_all_zero("mid_reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        run(3, 0, 3, 6, "replay");

        // Second start pulse while the run is in progress is ignored.
        load_sb(3);
        mon_en         = 1'b1;
        start          = 1'b1;
        num_records    = (ADDR_W+1)'(3);
        bus.step_ready = 1'b1;
        @(posedge clk); #1;
        start       = 1'b0;
        @(posedge clk); #1;
        start       = 1'b1;
        num_records = (ADDR_W+1)'(7);
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (!done && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("restart_done_seen", done, 1);
        check("restart_rec_count", rec_count, 3);
        check("restart_reads", rd_cnt, 3);
        check("restart_sb_empty", sb.size(), 0);
        @(posedge clk); #1;

`ifdef SEQ_ABORT_EN
        // Abort after four handshakes.
        load_sb(10);
        hs_cnt         = 0;
        mon_en         = 1'b1;
        start          = 1'b1;
        num_records    = (ADDR_W+1)'(10);
        bus.step_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (hs_cnt < 4 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("abort_hs_reached", hs_cnt, 4);
        mon_en         = 1'b0;
        bus.step_ready = 1'b0;
        abort          = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_valid", bus.step_valid, 0);
        check("abort_done", done, 1);
        check("abort_busy", busy, 0);
        check("abort_rec_count", rec_count, 4);
        check("abort_rd_en", bus.mem_rd_en, 0);
        sb.delete();
        @(posedge clk); #1;
        check("abort_done_pulse", done, 0);
        check("abort_count_hold", rec_count, 4);
        check("abort_valid_after", bus.step_valid, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
